// File: rtl/cgra_cfg_pkg.sv
// rtl/cgra_cfg_pkg.sv - shared types and constants for the CGRA configuration sequencer
package cgra_cfg_pkg;

  localparam int DEF_WIDTH     = 120;
  localparam int DEF_NUM_PE    = 16;
  localparam int DEF_CTX_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    RUN,
    DONE
  } state_t;

  // One extra code point so an out-of-range PE index can reach the sequencer and be rejected.
  function automatic int pe_idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pe_slot_counters.sv
// rtl/pe_slot_counters.sv - per-PE saturating context slot counters with indexed read
module pe_slot_counters
  import cgra_cfg_pkg::*;
#(
  parameter int NUM_PE = DEF_NUM_PE,
  parameter int CTX_DEPTH = DEF_CTX_DEPTH,
  localparam int IDX_W = pe_idx_w(NUM_PE),
  localparam int ADDR_W = $clog2(CTX_DEPTH),
  localparam int CNT_W = $clog2(CTX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic              full
);

  logic [CNT_W-1:0] cnt [NUM_PE];
  logic [CNT_W-1:0] cur;

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (idx == IDX_W'(i)) cur = cnt[i];
    end
  end

  assign addr = cur[ADDR_W-1:0];
  assign full = (cur == CNT_W'(CTX_DEPTH));

  // Counters stop at CTX_DEPTH; a full cache never wraps back onto slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PE; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (clr) cnt[i] <= '0;
        else if (inc && !full && idx == IDX_W'(i)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cgra_config_sequencer.sv
// rtl/cgra_config_sequencer.sv - loads PE context caches over the shared bus, then runs the array
module cgra_config_sequencer
  import cgra_cfg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_PE = DEF_NUM_PE,
  parameter int CTX_DEPTH = DEF_CTX_DEPTH,
  localparam int IDX_W = pe_idx_w(NUM_PE),
  localparam int ADDR_W = $clog2(CTX_DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              go,
  input  logic              abort,
  input  logic [7:0]        run_len,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IDX_W-1:0]  cfg_pe,
  input  logic              cfg_last,
  input  logic [WIDTH:0]    cfg_data,
  output logic [WIDTH:0]    data,
  output logic [NUM_PE-1:0] pe_wr,
  output logic [ADDR_W-1:0] ctx_addr,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  logic [7:0]        run_len_q;
  logic [7:0]        run_cnt;
  logic [ADDR_W-1:0] slot_addr;
  logic              slot_full;
  logic              xfer;
  logic              drop;

  assign xfer = cfg_valid && cfg_ready;
  assign drop = (cfg_pe >= IDX_W'(NUM_PE)) || slot_full;

  pe_slot_counters #(
    .NUM_PE(NUM_PE),
    .CTX_DEPTH(CTX_DEPTH)
  ) u_slots (
    .clk(CLK),
    .rst(RST),
    .clr(state == IDLE),
    .inc(xfer && !drop && !abort),
    .idx(cfg_pe),
    .addr(slot_addr),
    .full(slot_full)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      data      <= '0;
      pe_wr     <= '0;
      ctx_addr  <= '0;
      start     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cfg_ready <= 1'b0;
      run_len_q <= '0;
      run_cnt   <= '0;
    end else begin
      pe_wr <= '0;
      done  <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        start     <= 1'b0;
        busy      <= 1'b0;
        cfg_ready <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (go) begin
              state     <= LOAD;
              busy      <= 1'b1;
              cfg_ready <= 1'b1;
              err       <= 1'b0;
              run_len_q <= run_len;
            end
          end
          LOAD: begin
            if (xfer) begin
              if (drop) begin
                err <= 1'b1;
              end else begin
                data     <= cfg_data;
                pe_wr    <= NUM_PE'(1) << cfg_pe;
                ctx_addr <= slot_addr;
              end
              if (cfg_last) begin
                state     <= ARM;
                cfg_ready <= 1'b0;
              end
            end
          end
          ARM: begin
            if (run_len_q != 8'd0) begin
              state   <= RUN;
              start   <= 1'b1;
              run_cnt <= run_len_q;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          RUN: begin
            if (run_cnt == 8'd1) begin
              state <= DONE;
              start <= 1'b0;
              done  <= 1'b1;
            end else begin
              run_cnt <= run_cnt - 8'd1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// tb/tb_cgra_config_sequencer.sv - directed scoreboard bench for cgra_config_sequencer
module tb_cgra_config_sequencer;

  localparam int WIDTH = 120;
  localparam int NUM_PE = 16;
  localparam int CTX_DEPTH = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              go = 1'b0;
  logic              abort = 1'b0;
  logic [7:0]        run_len = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_last = 1'b0;
  logic [4:0]        cfg_pe = '0;
  logic [WIDTH:0]    cfg_data = '0;
  logic              cfg_ready;
  logic [WIDTH:0]    data;
  logic [NUM_PE-1:0] pe_wr;
  logic [3:0]        ctx_addr;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct {
    int             pe;
    int             addr;
    logic [WIDTH:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   model_cnt[NUM_PE];
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  int   dpulses = 0;
  bit   exp_err = 1'b0;

  cgra_config_sequencer #(
    .WIDTH(WIDTH),
    .NUM_PE(NUM_PE),
    .CTX_DEPTH(CTX_DEPTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .go(go),
    .abort(abort),
    .run_len(run_len),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_pe(cfg_pe),
    .cfg_last(cfg_last),
    .cfg_data(cfg_data),
    .data(data),
    .pe_wr(pe_wr),
    .ctx_addr(ctx_addr),
    .start(start),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && pe_wr !== '0) begin
      strobes++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 128'(pe_wr), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("pe_wr", 128'(pe_wr), 128'(1) << mon_e.pe);
        chk("ctx_addr", 128'(ctx_addr), 128'(mon_e.addr));
        chk("data", 128'(data), 128'(mon_e.d));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"}, 128'(data), 128'(0));
    chk({tag, "_pe_wr"}, 128'(pe_wr), 128'(0));
    chk({tag, "_ctx_addr"}, 128'(ctx_addr), 128'(0));
    chk({tag, "_start"}, 128'(start), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(0));
    chk({tag, "_cfg_ready"}, 128'(cfg_ready), 128'(0));
  endtask

  task automatic session_start(input int rl);
    go = 1'b1;
    run_len = 8'(rl);
    for (int i = 0; i < NUM_PE; i++) model_cnt[i] = 0;
    exp_err = 1'b0;
    @(posedge CLK);
    #1;
    go = 1'b0;
    chk("go_busy", 128'(busy), 128'(1));
    chk("go_cfg_ready", 128'(cfg_ready), 128'(1));
    chk("go_err_clear", 128'(err), 128'(0));
  endtask

  task automatic send(input int pe, input bit last);
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    cfg_valid = 1'b1;
    cfg_pe = 5'(pe);
    cfg_last = last;
    cfg_data = r[WIDTH:0];
    if (pe < NUM_PE && model_cnt[pe] < CTX_DEPTH) begin
      sb.push_back('{pe, model_cnt[pe], r[WIDTH:0]});
      model_cnt[pe]++;
    end else begin
      exp_err = 1'b1;
    end
    @(posedge CLK);
    #1;
    cfg_valid = 1'b0;
    cfg_last = 1'b0;
  endtask

  // Entered in the cycle right after the last transfer (the ARM cycle).
  task automatic run_phase(input int rl);
    chk("arm_start", 128'(start), 128'(0));
    chk("arm_cfg_ready", 128'(cfg_ready), 128'(0));
    chk("arm_busy", 128'(busy), 128'(1));
    chk("arm_err", 128'(err), 128'(exp_err));
    for (int i = 0; i < rl; i++) begin
      @(posedge CLK);
      #1;
      chk("run_start", 128'(start), 128'(1));
      chk("run_done", 128'(done), 128'(0));
    end
    @(posedge CLK);
    #1;
    chk("done_pulse", 128'(done), 128'(1));
    chk("done_start", 128'(start), 128'(0));
    @(posedge CLK);
    #1;
    chk("idle_done", 128'(done), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_err", 128'(err), 128'(exp_err));
    chk("sb_empty", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    #1 RST = 1'b1;
    #1 check_all_zero("reset");
    @(posedge CLK);
    #1 RST = 1'b0;

    // mixed targets, per-PE addresses
    session_start(4);
    send(2, 1'b0);
    send(2, 1'b0);
    send(2, 1'b0);
    send(5, 1'b1);
    run_phase(4);

    // overfill one PE cache
    session_start(1);
    strobes = 0;
    for (int i = 0; i < 16; i++) send(0, 1'b0);
    chk("fill_err_before", 128'(err), 128'(0));
    send(0, 1'b1);
    run_phase(1);
    chk("fill_strobes", 128'(strobes), 128'(16));

    // out-of-range PE index
    session_start(2);
    send(16, 1'b0);
    chk("badpe_err", 128'(err), 128'(1));
    chk("badpe_ready", 128'(cfg_ready), 128'(1));
    send(3, 1'b1);
    run_phase(2);

    // zero run length
    session_start(0);
    send(7, 1'b1);
    run_phase(0);

    // abort on second RUN cycle
    session_start(10);
    send(1, 1'b1);
    @(posedge CLK);
    #1 chk("abort_run1", 128'(start), 128'(1));
    @(posedge CLK);
    #1 chk("abort_run2", 128'(start), 128'(1));
    abort = 1'b1;
    @(posedge CLK);
    #1 abort = 1'b0;
    chk("abort_start", 128'(start), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_ready", 128'(cfg_ready), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    dpulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      #1;
      if (done) dpulses++;
    end
    chk("abort_no_done", 128'(dpulses), 128'(0));
    chk("abort_sb_empty", 128'(sb.size()), 128'(0));

    // asynchronous reset mid-load with a word pending
    session_start(3);
    send(4, 1'b0);
    @(negedge CLK);
    cfg_valid = 1'b1;
    cfg_pe = 5'd4;
    cfg_data = '1;
    #2 RST = 1'b1;
    #1 check_all_zero("rst_mid");
    @(posedge CLK);
    #1;
    chk("rst_hold_pe_wr", 128'(pe_wr), 128'(0));
    chk("rst_hold_ready", 128'(cfg_ready), 128'(0));
    RST = 1'b0;
    cfg_valid = 1'b0;
    session_start(3);
    send(4, 1'b1);
    run_phase(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
